cc_psr_condition: RTL and testbench

- Processor status / condition-code stage directly downstream of the datapath ALU.
- Latches the ALU N/Z/V/C flags when the ALU reports a condition-code-setting operation and the microsequencer strobes a write.
- Evaluates SPARC-style Bicc branch conditions against the latched flags through a registered request/valid handshake, and returns branch-taken to the control unit.

---
 rtl/cc_psr_condition.sv | 139 +++++++++++++
 tb/tb_cc_psr_condition.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_psr_condition.sv
// -----------------------------------------------------------------------------
// cc_psr_condition
//
// Processor status / condition-code stage that sits right after the ALU.
// It keeps the architectural N/Z/V/C flags and answers SPARC Bicc branch
// questions against them through a two-cycle request/valid handshake.
//
// Ports
//   CC_PSR_CLOCK_50          in   system clock, rising edge
//   CC_PSR_RESET_InLow       in   synchronous active-low reset
//   CC_PSR_negative_InHigh   in   ALU N flag
//   CC_PSR_zero_InHigh       in   ALU Z flag
//   CC_PSR_overflow_InHigh   in   ALU V flag
//   CC_PSR_carry_InHigh      in   ALU C flag
//   CC_PSR_scc_InHigh        in   ALU operation sets condition codes
//   CC_PSR_write_InHigh      in   microcode flag-write strobe
//   CC_PSR_load_InHigh       in   direct PSR load (WRPSR), beats write+scc
//   CC_PSR_data_InBUS        in   direct load value {N,Z,V,C}
//   CC_PSR_condition_InBUS   in   Bicc cond field
//   CC_PSR_evaluate_InHigh   in   branch evaluation request
//   CC_PSR_flags_OutBUS      out  latched flags {N,Z,V,C}
//   CC_PSR_branch_OutHigh    out  branch taken, holds until next evaluation
//   CC_PSR_valid_OutHigh     out  one-cycle pulse, branch result valid
//   CC_PSR_busy_OutHigh      out  evaluation in progress
// -----------------------------------------------------------------------------
module cc_psr_condition #(
    parameter int DATAWIDTH_FLAGS     = 4,
    parameter int DATAWIDTH_CONDITION = 4
) (
    input  logic                           CC_PSR_CLOCK_50,
    input  logic                           CC_PSR_RESET_InLow,
    input  logic                           CC_PSR_negative_InHigh,
    input  logic                           CC_PSR_zero_InHigh,
    input  logic                           CC_PSR_overflow_InHigh,
    input  logic                           CC_PSR_carry_InHigh,
    input  logic                           CC_PSR_scc_InHigh,
    input  logic                           CC_PSR_write_InHigh,
    input  logic                           CC_PSR_load_InHigh,
    input  logic [DATAWIDTH_FLAGS-1:0]     CC_PSR_data_InBUS,
    input  logic [DATAWIDTH_CONDITION-1:0] CC_PSR_condition_InBUS,
    input  logic                           CC_PSR_evaluate_InHigh,
    output logic [DATAWIDTH_FLAGS-1:0]     CC_PSR_flags_OutBUS,
    output logic                           CC_PSR_branch_OutHigh,
    output logic                           CC_PSR_valid_OutHigh,
    output logic                           CC_PSR_busy_OutHigh
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EVAL = 1'b1
    } state_e;

    state_e                         state_q,  state_d;
    logic [DATAWIDTH_FLAGS-1:0]     flags_q,  flags_d;
    logic [DATAWIDTH_CONDITION-1:0] cond_q,   cond_d;
    logic                           branch_q, branch_d;
    logic                           valid_q,  valid_d;

    // Bicc decode: cond[2:0] selects a base term, cond[3] inverts it.
    // Flags are packed {N,Z,V,C}.
    function automatic logic cond_taken(input logic [3:0] cond,
                                        input logic [3:0] flags);
        logic n, z, v, c, base;
        n = flags[3];
        z = flags[2];
        v = flags[1];
        c = flags[0];
        case (cond[2:0])
            3'd0:    base = 1'b0;          // BN  / BA
            3'd1:    base = z;             // BE  / BNE
            3'd2:    base = z | (n ^ v);   // BLE / BG
            3'd3:    base = n ^ v;         // BL  / BGE
            3'd4:    base = c | z;         // BLEU/ BGU
            3'd5:    base = c;             // BCS / BCC
            3'd6:    base = n;             // BNEG/ BPOS
            default: base = v;             // BVS / BVC
        endcase
        return base ^ cond[3];
    endfunction

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through
        // the case/if tree can leave it unassigned and infer a latch.
        state_d  = state_q;
        flags_d  = flags_q;
        cond_d   = cond_q;
        branch_d = branch_q;
        valid_d  = 1'b0;

        // Direct load outranks an ALU write; a write needs scc to land.
        if (CC_PSR_load_InHigh) begin
            flags_d = CC_PSR_data_InBUS;
        end else if (CC_PSR_write_InHigh && CC_PSR_scc_InHigh) begin
            flags_d = {CC_PSR_negative_InHigh, CC_PSR_zero_InHigh,
                       CC_PSR_overflow_InHigh, CC_PSR_carry_InHigh};
        end

        case (state_q)
            ST_IDLE: begin
                if (CC_PSR_evaluate_InHigh) begin
                    cond_d  = CC_PSR_condition_InBUS;
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                // flags_q already holds any write made on the request edge,
                // while a write on this edge is not yet visible.
                branch_d = cond_taken(cond_q, flags_q);
                valid_d  = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CC_PSR_CLOCK_50) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge
        // value of the others; the reset here is synchronous, checked first.
        if (!CC_PSR_RESET_InLow) begin
            state_q  <= ST_IDLE;
            flags_q  <= '0;
            cond_q   <= '0;
            branch_q <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            flags_q  <= flags_d;
            cond_q   <= cond_d;
            branch_q <= branch_d;
            valid_q  <= valid_d;
        end
    end

    assign CC_PSR_flags_OutBUS   = flags_q;
    assign CC_PSR_branch_OutHigh = branch_q;
    assign CC_PSR_valid_OutHigh  = valid_q;
    assign CC_PSR_busy_OutHigh   = (state_q == ST_EVAL);

endmodule

// File: tb/tb_cc_psr_condition.sv
// -----------------------------------------------------------------------------
// tb_cc_psr_condition
//
// Directed and randomized stimulus for cc_psr_condition. A cycle-level
// reference model written from the branch mnemonics predicts flags, branch,
// valid and busy after every clock edge.
// -----------------------------------------------------------------------------
module tb_cc_psr_condition;

    logic       clk;
    logic       rst_n;
    logic       in_n, in_z, in_v, in_c;
    logic       scc, write, load;
    logic [3:0] data;
    logic [3:0] cond;
    logic       evaluate;
    logic [3:0] flags_out;
    logic       branch_out, valid_out, busy_out;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [3:0] m_flags;
    logic       m_branch, m_valid, m_pending;
    logic [3:0] m_cond;

    cc_psr_condition #(
        .DATAWIDTH_FLAGS    (4),
        .DATAWIDTH_CONDITION(4)
    ) dut (
        .CC_PSR_CLOCK_50       (clk),
        .CC_PSR_RESET_InLow    (rst_n),
        .CC_PSR_negative_InHigh(in_n),
        .CC_PSR_zero_InHigh    (in_z),
        .CC_PSR_overflow_InHigh(in_v),
        .CC_PSR_carry_InHigh   (in_c),
        .CC_PSR_scc_InHigh     (scc),
        .CC_PSR_write_InHigh   (write),
        .CC_PSR_load_InHigh    (load),
        .CC_PSR_data_InBUS     (data),
        .CC_PSR_condition_InBUS(cond),
        .CC_PSR_evaluate_InHigh(evaluate),
        .CC_PSR_flags_OutBUS   (flags_out),
        .CC_PSR_branch_OutHigh (branch_out),
        .CC_PSR_valid_OutHigh  (valid_out),
        .CC_PSR_busy_OutHigh   (busy_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Branch outcome by mnemonic, flags packed {N,Z,V,C}.
    function automatic logic ref_taken(input logic [3:0] c, input logic [3:0] f);
        logic n, z, v, cy;
        n  = f[3];
        z  = f[2];
        v  = f[1];
        cy = f[0];
        case (c)
            4'h0: return 1'b0;              // BN
            4'h1: return z;                 // BE
            4'h2: return z || (n != v);     // BLE
            4'h3: return n != v;            // BL
            4'h4: return cy || z;           // BLEU
            4'h5: return cy;                // BCS
            4'h6: return n;                 // BNEG
            4'h7: return v;                 // BVS
            4'h8: return 1'b1;              // BA
            4'h9: return !z;                // BNE
            4'hA: return !z && (n == v);    // BG
            4'hB: return n == v;            // BGE
            4'hC: return !cy && !z;         // BGU
            4'hD: return !cy;               // BCC
            4'hE: return !n;                // BPOS
            default: return !v;             // BVC
        endcase
    endfunction

    task automatic check(input string tag, input logic [3:0] observed,
                         input logic [3:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance one clock: predict from the inputs now applied, then compare.
    task automatic tick(input string tag);
        logic [3:0] nf, nc;
        logic       nb, nv, np;
        if (!rst_n) begin
            nf = 4'h0; nb = 1'b0; nv = 1'b0; np = 1'b0; nc = 4'h0;
        end else begin
            nf = m_flags; nb = m_branch; nv = 1'b0; np = m_pending; nc = m_cond;
            if (load)              nf = data;
            else if (write && scc) nf = {in_n, in_z, in_v, in_c};
            if (m_pending) begin
                nb = ref_taken(m_cond, m_flags);
                nv = 1'b1;
                np = 1'b0;
            end else if (evaluate) begin
                np = 1'b1;
                nc = cond;
            end
        end
        @(posedge clk);
        #1;
        m_flags = nf; m_branch = nb; m_valid = nv; m_pending = np; m_cond = nc;
        check({tag, "/flags"},  flags_out,         m_flags);
        check({tag, "/branch"}, {3'b0, branch_out}, {3'b0, m_branch});
        check({tag, "/valid"},  {3'b0, valid_out},  {3'b0, m_valid});
        check({tag, "/busy"},   {3'b0, busy_out},   {3'b0, m_pending});
    endtask

    task automatic load_flags(input logic [3:0] f);
        load = 1'b1;
        data = f;
        tick("load");
        load = 1'b0;
    endtask

    initial begin
        logic [3:0] pats [6];
        int         pulses;
        logic [5:0] pulse_mask;

        pats = '{4'b0000, 4'b0100, 4'b1000, 4'b1010, 4'b0001, 4'b1111};
        m_flags = 4'h0; m_branch = 1'b0; m_valid = 1'b0; m_pending = 1'b0; m_cond = 4'h0;
        rst_n = 1'b0;
        {in_n, in_z, in_v, in_c} = 4'b0000;
        scc = 1'b0; write = 1'b0; load = 1'b0; data = 4'h0; cond = 4'h0; evaluate = 1'b0;

        // Reset overrides a concurrent load
        load = 1'b1;
        data = 4'b1111;
        tick("reset1");
        tick("reset2");
        check("reset_flags_zero", flags_out, 4'b0000);
        rst_n = 1'b1;
        load  = 1'b0;
        tick("release1");
        tick("release2");

        // Write without scc is ignored, with scc it lands
        {in_n, in_z, in_v, in_c} = 4'b1010;
        write = 1'b1;
        tick("write_no_scc");
        check("write_no_scc_hold", flags_out, 4'b0000);
        scc = 1'b1;
        tick("write_scc");
        check("write_scc_latch", flags_out, 4'b1010);

        // Load beats write+scc
        {in_n, in_z, in_v, in_c} = 4'b1111;
        load = 1'b1;
        data = 4'b0100;
        tick("load_prio");
        check("load_prio_value", flags_out, 4'b0100);
        load = 1'b0; write = 1'b0; scc = 1'b0;

        // Same-edge write is visible to the evaluation
        load_flags(4'b0000);
        {in_n, in_z, in_v, in_c} = 4'b0100;
        write = 1'b1; scc = 1'b1;
        evaluate = 1'b1;
        cond = 4'b0001;
        tick("hazard_req");
        check("hazard_busy", {3'b0, busy_out}, 4'd1);
        write = 1'b0; scc = 1'b0; evaluate = 1'b0;
        tick("hazard_res");
        check("hazard_valid",  {3'b0, valid_out},  4'd1);
        check("hazard_branch", {3'b0, branch_out}, 4'd1);

        // Decode sweep
        foreach (pats[p]) begin
            for (int c = 0; c < 16; c++) begin
                load_flags(pats[p]);
                cond     = 4'(c);
                evaluate = 1'b1;
                tick("sweep_req");
                evaluate = 1'b0;
                tick("sweep_res");
                if (pats[p] == 4'b1010 && c == 4'hA) check("bg_1010",  {3'b0, branch_out}, 4'd1);
                if (pats[p] == 4'b0001 && c == 4'hC) check("bgu_0001", {3'b0, branch_out}, 4'd0);
                if (c == 8) check("ba_taken",   {3'b0, branch_out}, 4'd1);
                if (c == 0) check("bn_untaken", {3'b0, branch_out}, 4'd0);
                tick("sweep_idle");
            end
        end

        // Evaluate held high for six cycles: pulses on cycles 2, 4, 6
        pulses     = 0;
        pulse_mask = '0;
        evaluate   = 1'b1;
        cond       = 4'h8;
        for (int i = 0; i < 6; i++) begin
            tick("held");
            if (valid_out === 1'b1) begin
                pulses++;
                pulse_mask[i] = 1'b1;
            end
        end
        evaluate = 1'b0;
        check("held_pulse_count", 4'(pulses), 4'd3);
        check("held_pulse_lo", pulse_mask[3:0], 4'b1010);
        check("held_pulse_hi", {2'b0, pulse_mask[5:4]}, 4'b0010);
        tick("held_drain");

        // Reset while evaluating aborts without a valid pulse
        evaluate = 1'b1;
        cond     = 4'h8;
        tick("abort_req");
        evaluate = 1'b0;
        rst_n    = 1'b0;
        tick("abort_rst");
        check("abort_valid", {3'b0, valid_out}, 4'd0);
        check("abort_busy",  {3'b0, busy_out},  4'd0);
        rst_n = 1'b1;
        tick("abort_after");
        check("abort_after_valid", {3'b0, valid_out}, 4'd0);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 29) != 0);
            {in_n, in_z, in_v, in_c} = 4'($urandom);
            scc      = 1'($urandom);
            write    = 1'($urandom);
            load     = ($urandom_range(0, 3) == 0);
            data     = 4'($urandom);
            cond     = 4'($urandom);
            evaluate = 1'($urandom);
            tick("rand");
        end
        rst_n = 1'b1; load = 1'b0; write = 1'b0; evaluate = 1'b0;
        tick("final1");
        tick("final2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
